// File: rtl/bpf_pkg.sv
// Shared band codes, FSM states and frame helper
// for the band-pass filter relay driver.
package bpf_pkg;

  localparam logic [2:0] BAND_6M_12M5  = 3'd0;
  localparam logic [2:0] BAND_20M_30M  = 3'd1;
  localparam logic [2:0] BAND_2M5_6M   = 3'd2;
  localparam logic [2:0] BAND_12M5_20M = 3'd3;
  localparam logic [2:0] BAND_0_2M5    = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SHIFT,
    ST_LATCH,
    ST_SETTLE
  } bpf_state_e;

  function automatic logic [7:0] onehot8(
    input logic [2:0] c
  );
    onehot8 = 8'd1 << c;
  endfunction

endpackage

// File: rtl/bpf_relay_drv_if.sv
// Serial bus to the filter-board 74HC595:
// shift clock, data and storage latch.
interface bpf_relay_drv_if;
  logic sr_sck;
  logic sr_data;
  logic sr_latch;

  modport master (
    output sr_sck,
    output sr_data,
    output sr_latch
  );

  modport slave (
    input sr_sck,
    input sr_data,
    input sr_latch
  );
endinterface

// File: rtl/bpf_shift_out.sv
// 8-bit MSB-first serializer with SCK divider;
// one-cycle start in, one-cycle done out.
import bpf_pkg::*;

module bpf_shift_out #(
  parameter int SCK_HALF = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start_i,
  input  logic [7:0] frame_i,
  output logic       sck_o,
  output logic       data_o,
  output logic       done_o
);

  localparam int DW =
    (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;

  logic [DW-1:0] div_q, div_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sr_q, sr_d;
  logic          sck_q, sck_d;
  logic          act_q, act_d;
  logic          half_end;

  assign half_end = div_q == DW'(SCK_HALF - 1);

  always_comb begin
    div_d  = div_q;
    bit_d  = bit_q;
    sr_d   = sr_q;
    sck_d  = sck_q;
    act_d  = act_q;
    done_o = 1'b0;
    if (start_i) begin
      div_d = '0;
      bit_d = '0;
      sr_d  = frame_i;
      sck_d = 1'b0;
      act_d = 1'b1;
    end else if (act_q) begin
      div_d = half_end ? '0 : div_q + 1'b1;
      if (half_end) begin
        sck_d = ~sck_q;
        // data advances only on the falling SCK edge
        if (sck_q) begin
          sr_d  = {sr_q[6:0], 1'b0};
          bit_d = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
            act_d  = 1'b0;
            done_o = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= '0;
      bit_q <= '0;
      sr_q  <= '0;
      sck_q <= 1'b0;
      act_q <= 1'b0;
    end else begin
      div_q <= div_d;
      bit_q <= bit_d;
      sr_q  <= sr_d;
      sck_q <= sck_d;
      act_q <= act_d;
    end
  end

  assign sck_o  = sck_q;
  assign data_o = sr_q[7];

endmodule

// File: rtl/bpf_relay_drv.sv
// Band-filter relay driver: debounces the band code,
// mutes, shifts a one-hot frame, latches and settles.
import bpf_pkg::*;

module bpf_relay_drv #(
  parameter int STABLE_CYC = 1024,
  parameter int PRE_CYC    = 64,
  parameter int SCK_HALF   = 8,
  parameter int SETTLE_CYC = 245760
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       bpf_req,
  input  logic             force_i,
  bpf_relay_drv_if.master  sr,
  output logic             mute,
  output logic             busy,
  output logic [2:0]       bpf_cur
);

  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam int TW = 32;

  bpf_state_e    st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [2:0]    req_q;
  logic [2:0]    code_q, code_d;
  logic [2:0]    cur_q, cur_d;
  logic          pend_q, pend_d;
  logic          first_q, first_d;
  logic          mute_q, mute_d;
  logic          latch_q, latch_d;
  logic          sat, xfer, start, done;
  logic          sck_w, dat_w;
  logic [7:0]    frame_w;

  assign sat  = cnt_q == CW'(STABLE_CYC - 1);
  assign xfer = sat &&
    (req_q != cur_q || pend_q || first_q);

  always_comb begin
    cnt_d = cnt_q;
    if (bpf_req != req_q) cnt_d = '0;
    else if (!sat)        cnt_d = cnt_q + 1'b1;
  end

  always_comb begin
    st_d    = st_q;
    tmr_d   = tmr_q + 1'b1;
    code_d  = code_q;
    cur_d   = cur_q;
    mute_d  = mute_q;
    latch_d = latch_q;
    first_d = first_q;
    pend_d  = pend_q | force_i;
    start   = 1'b0;
    unique case (st_q)
      ST_IDLE: begin
        tmr_d = '0;
        if (xfer) begin
          st_d    = ST_PRE;
          code_d  = req_q;
          mute_d  = 1'b1;
          first_d = 1'b0;
          pend_d  = force_i;
        end
      end
      ST_PRE: begin
        if (tmr_q == TW'(PRE_CYC - 1)) begin
          st_d  = ST_SHIFT;
          start = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (done) begin
          st_d    = ST_LATCH;
          tmr_d   = '0;
          latch_d = 1'b1;
          cur_d   = code_q;
        end
      end
      ST_LATCH: begin
        if (tmr_q == TW'(SCK_HALF - 1)) begin
          st_d    = ST_SETTLE;
          tmr_d   = '0;
          latch_d = 1'b0;
        end
      end
      ST_SETTLE: begin
        if (tmr_q == TW'(SETTLE_CYC - 1)) begin
          st_d   = ST_IDLE;
          mute_d = 1'b0;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q    <= ST_IDLE;
      cnt_q   <= '0;
      tmr_q   <= '0;
      req_q   <= '0;
      code_q  <= '0;
      cur_q   <= '0;
      pend_q  <= 1'b0;
      first_q <= 1'b1;
      mute_q  <= 1'b1;
      latch_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      req_q   <= bpf_req;
      code_q  <= code_d;
      cur_q   <= cur_d;
      pend_q  <= pend_d;
      first_q <= first_d;
      mute_q  <= mute_d;
      latch_q <= latch_d;
    end
  end

  assign frame_w = onehot8(code_q);

  bpf_shift_out #(
    .SCK_HALF(SCK_HALF)
  ) u_shift (
    .clk     (clk),
    .reset_n (reset_n),
    .start_i (start),
    .frame_i (frame_w),
    .sck_o   (sck_w),
    .data_o  (dat_w),
    .done_o  (done)
  );

  assign sr.sr_sck   = sck_w;
  assign sr.sr_data  = dat_w;
  assign sr.sr_latch = latch_q;
  assign mute        = mute_q;
  assign busy        = st_q != ST_IDLE;
  assign bpf_cur     = cur_q;

endmodule

// File: tb/tb_bpf_relay_drv.sv
// Directed bench for bpf_relay_drv with small
// timing parameters and a serial-bus monitor.
module tb_bpf_relay_drv;

  localparam int H = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] bpf_req = 3'd6;
  logic       force_i = 1'b0;
  logic       mute, busy;
  logic [2:0] bpf_cur;

  bpf_relay_drv_if sr_if ();

  bpf_relay_drv #(
    .STABLE_CYC(4),
    .PRE_CYC(3),
    .SCK_HALF(H),
    .SETTLE_CYC(10)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bpf_req (bpf_req),
    .force_i (force_i),
    .sr      (sr_if),
    .mute    (mute),
    .busy    (busy),
    .bpf_cur (bpf_cur)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  int         cyc = 0;
  int         nrise = 0;
  int         last_rise = 0;
  int         nlatch = 0;
  int         nbusy = 0;
  logic [7:0] acc = 8'd0;
  logic [7:0] frames[$];
  logic       sck_p = 1'b0;
  logic       dat_p = 1'b0;
  logic       lat_p = 1'b0;
  logic       busy_p = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      nrise = 0;
      acc   = 8'd0;
    end else begin
      if (sr_if.sr_sck && !sck_p) begin
        chk("data_hold", 32'(sr_if.sr_data),
            32'(dat_p));
        if (nrise > 0)
          chk("sck_period", 32'(cyc - last_rise),
              32'(2 * H));
        last_rise = cyc;
        nrise++;
        acc = {acc[6:0], sr_if.sr_data};
      end
      if (sr_if.sr_latch && !lat_p) begin
        chk("nrise", 32'(nrise), 32'd8);
        chk("latch_sck", 32'(sr_if.sr_sck), 32'd0);
        chk("latch_mute", 32'(mute), 32'd1);
        chk("latch_cur", 32'(8'd1 << bpf_cur),
            32'(acc));
        frames.push_back(acc);
        nlatch++;
        nrise = 0;
        acc   = 8'd0;
      end
      if (busy && !busy_p) nbusy++;
    end
    sck_p  = sr_if.sr_sck;
    dat_p  = sr_if.sr_data;
    lat_p  = sr_if.sr_latch;
    busy_p = busy;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_busy(
    input  logic v,
    output int   n
  );
    n = 0;
    while (busy !== v && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy !== v)
      chk("timeout", 32'(busy), 32'(v));
  endtask

  task automatic chk_frame(
    input string      tag,
    input int         idx,
    input logic [7:0] exp
  );
    chk(tag, (idx < frames.size()) ?
        32'(frames[idx]) : 32'hdead, 32'(exp));
  endtask

  initial begin
    int n;
    int nb0;
    step(2);
    chk("rst_sck", 32'(sr_if.sr_sck), 32'd0);
    chk("rst_data", 32'(sr_if.sr_data), 32'd0);
    chk("rst_latch", 32'(sr_if.sr_latch), 32'd0);
    chk("rst_mute", 32'(mute), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cur", 32'(bpf_cur), 32'd0);
    reset_n = 1'b1;
    step(1);
    chk("pre_mute", 32'(mute), 32'd1);

    wait_busy(1'b1, n);
    chk("t1_start", 32'(n), 32'd4);
    wait_busy(1'b0, n);
    chk("t1_lat", 32'(n), 32'd47);
    chk("t1_mute", 32'(mute), 32'd0);
    chk("t1_cur", 32'(bpf_cur), 32'd6);
    chk_frame("t1_frame", 0, 8'b0100_0000);

    bpf_req = 3'd3;
    step(3);
    bpf_req = 3'd6;
    step(20);
    chk("t2_glitch", 32'(nbusy), 32'd1);
    bpf_req = 3'd3;
    wait_busy(1'b1, n);
    chk("t2_start", 32'(n), 32'd5);
    wait_busy(1'b0, n);
    chk("t2_lat", 32'(n), 32'd47);
    chk("t2_cur", 32'(bpf_cur), 32'd3);
    chk_frame("t2_frame", 1, 8'b0000_1000);

    bpf_req = 3'd0;
    wait_busy(1'b1, n);
    step(8);
    bpf_req = 3'd1;
    wait_busy(1'b0, n);
    chk("t3_cur0", 32'(bpf_cur), 32'd0);
    chk_frame("t3_frame0", 2, 8'b0000_0001);
    step(1);
    chk("t3_restart", 32'(busy), 32'd1);
    wait_busy(1'b0, n);
    chk("t3_lat", 32'(n), 32'd47);
    chk("t3_cur1", 32'(bpf_cur), 32'd1);
    chk_frame("t3_frame1", 3, 8'b0000_0010);

    nb0 = nbusy;
    force_i = 1'b1;
    step(1);
    force_i = 1'b0;
    wait_busy(1'b1, n);
    chk("t4_start", 32'(n), 32'd1);
    step(40);
    force_i = 1'b1;
    step(1);
    force_i = 1'b0;
    wait_busy(1'b0, n);
    step(1);
    chk("t4_extra", 32'(busy), 32'd1);
    wait_busy(1'b0, n);
    step(20);
    chk("t4_nbusy", 32'(nbusy - nb0), 32'd2);
    chk("t4_nlatch", 32'(nlatch), 32'd6);
    chk_frame("t4_frame0", 4, 8'b0000_0010);
    chk_frame("t4_frame1", 5, 8'b0000_0010);
    chk("t4_cur", 32'(bpf_cur), 32'd1);

    bpf_req = 3'd2;
    wait_busy(1'b1, n);
    step(20);
    reset_n = 1'b0;
    step(2);
    chk("t5_nlatch", 32'(nlatch), 32'd6);
    chk("t5_cur", 32'(bpf_cur), 32'd0);
    chk("t5_mute", 32'(mute), 32'd1);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_sck", 32'(sr_if.sr_sck), 32'd0);
    bpf_req = 3'd0;
    reset_n = 1'b1;
    step(1);
    wait_busy(1'b1, n);
    chk("t5_start", 32'(n), 32'd3);
    wait_busy(1'b0, n);
    chk("t5_lat", 32'(n), 32'd47);
    chk("t5_mute_off", 32'(mute), 32'd0);
    chk("t5_cur2", 32'(bpf_cur), 32'd0);
    chk_frame("t5_frame", 6, 8'b0000_0001);
    chk("t5_nlatch2", 32'(nlatch), 32'd7);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
